uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
Sequencing controller for the UART transmit path. It accepts a parallel byte with a valid strobe and serializes it LSB-first. It computes the frame parity and drives the 2-bit select of the TX output mux (00=start, 01=idle/stop, 10=serial data, 11=parity) together with that mux's serial-data and parity-bit inputs. It runs on the TX baud clock, so one CLK cycle equals one bit time.

Parameters:
DATA_WIDTH, 8, width of P_DATA and the number of data bits per frame (range 5..9).

Ports:
CLK  input  1  TX baud clock; all state updates on the rising edge.
RST  input  1  asynchronous, active-low reset.
P_DATA  input  DATA_WIDTH  parallel data to transmit.
Data_Valid  input  1  one-cycle strobe; P_DATA is valid while it is high.
PAR_EN  input  1  1 inserts a parity bit after the data bits.
PAR_TYP  input  1  0 selects even parity, 1 selects odd parity.
SEL  output  2  select for the TX output mux.
Ser_Data  output  1  current data bit, fed to the mux data input.
Par_Bit  output  1  frame parity bit, fed to the mux parity input.
Busy  output  1  high while a frame is on the line.

Behaviour:
- Reset (RST low, asynchronous, any state, including mid-frame): state=IDLE, SEL=01 so the line idles high. Busy=0, Ser_Data=0, Par_Bit=0, bit counter=0, shift register=0. The frame in progress is dropped and nothing resumes after reset release.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered and change only on CLK edges.
- SEL per state: IDLE=01, START=00, DATA=10, PARITY=11, STOP=01.
- Accepting a frame:
  - Data_Valid=1 is accepted only in IDLE, or in the final STOP cycle (back-to-back frames).
  - On the accepting edge the block latches P_DATA into the shift register and latches PAR_EN and PAR_TYP.
  - Par_Bit is set on that same edge: even parity = XOR-reduction of P_DATA; odd parity = its inverse.
  - The next state is START with Busy=1.
- Data_Valid in any other state is ignored and has no side effects.
- Latency: Data_Valid sampled high at edge k puts SEL=00 in the cycle after edge k. There is no idle cycle between back-to-back frames.
- START (1 cycle) goes to DATA. Ser_Data is preloaded with bit0 on the edge that enters DATA.
- DATA: lasts exactly DATA_WIDTH cycles. The bit counter counts 0..DATA_WIDTH-1, and the shift register shifts right each cycle so Ser_Data carries bits 0,1,...,N-1 in order. On the last count the counter clears to 0. The next state is PARITY if the latched PAR_EN=1, otherwise STOP.
- PARITY (1 cycle) goes to STOP.
- STOP (1 cycle) goes to START if a new frame is accepted; otherwise it goes to IDLE and Busy falls on that edge.
- Frame length is 1 + DATA_WIDTH + PAR_EN + 1 cycles, plus 1 more when the optional feature is compiled in.
- Changes to PAR_EN or PAR_TYP mid-frame have no effect on the current frame.
- Busy is high from the first START cycle through the last STOP cycle inclusive.
- Ser_Data and Par_Bit hold their last values outside DATA and PARITY; the mux ignores them in those states.

Optional Feature:
UART_TX_STOP2_EN.
- Defined: STOP lasts 2 cycles (SEL=01 for both). A back-to-back Data_Valid is accepted only in the second stop cycle; Data_Valid in the first stop cycle is ignored.
- Undefined: one stop cycle, exactly as described in Behaviour.

Test Plan:
1. Reset then idle. Hold RST low for 3 cycles, release, keep Data_Valid=0 for 10 cycles -> SEL=01 and Busy=0 throughout, Ser_Data=0, Par_Bit=0.
2. Even-parity frame. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> SEL sequence 00, then 10 x8, then 11, then 01. Ser_Data=1,0,1,0,0,1,0,1. Par_Bit=0. Busy high for exactly 11 cycles, then SEL=01 and Busy=0.
3. Odd parity, then parity disabled. Send 0x01 with PAR_EN=1, PAR_TYP=1 -> Par_Bit=0. Then send 0x01 with PAR_EN=0 -> no SEL=11 cycle and Busy high for exactly 10 cycles.
4. Back-to-back frames. Assert Data_Valid with 0x3C in the STOP cycle of a 0xFF frame -> SEL goes 01 to 00 with no IDLE cycle between, Busy stays high, second frame's Ser_Data=0,0,1,1,1,1,0,0.
5. Ignored inputs. Pulse Data_Valid with 0x00 during DATA, and toggle PAR_TYP mid-frame -> the current frame's bits and parity are unchanged and no extra frame is sent.
6. Reset mid-frame. Assert RST in the 4th DATA cycle -> SEL=01 and Busy=0 immediately (asynchronous). After release the block stays IDLE until a new Data_Valid. With UART_TX_STOP2_EN defined, repeat scenario 2 -> two stop cycles with SEL=01 and Busy high for 12 cycles.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start/data/parity/stop framing, TX mux select, LSB-first shift.
// Define UART_TX_STOP2_EN to transmit two stop bits per frame.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            SEL,
  output logic                  Ser_Data,
  output logic                  Par_Bit,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP
  } state_t;

  // S_STOP is always the final stop cycle, the only one that may accept a new frame.
`ifdef UART_TX_STOP2_EN
  localparam state_t STOP_ENTRY = S_STOP1;
`else
  localparam state_t STOP_ENTRY = S_STOP;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_en_q, par_en_d;
  logic [1:0]              sel_q, sel_d;
  logic                    ser_q, ser_d;
  logic                    par_q, par_d;
  logic                    busy_q, busy_d;
  logic                    accept;

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      S_START:  sel_of = 2'b00;
      S_DATA:   sel_of = 2'b10;
      S_PARITY: sel_of = 2'b11;
      default:  sel_of = 2'b01;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    par_en_d = par_en_q;
    ser_d    = ser_q;
    par_d    = par_q;
    accept   = Data_Valid && ((state_q == S_IDLE) || (state_q == S_STOP));

    case (state_q)
      S_IDLE, S_STOP: begin
        if (accept) begin
          state_d  = S_START;
          shreg_d  = P_DATA;
          par_en_d = PAR_EN;
          par_d    = (^P_DATA) ^ PAR_TYP;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_DATA;
        ser_d   = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
      S_DATA: begin
        // Ser_Data for the next bit is loaded on the edge that ends the current one.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? S_PARITY : STOP_ENTRY;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          ser_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      S_PARITY: state_d = STOP_ENTRY;
      S_STOP1:  state_d = S_STOP;
      default:  state_d = S_IDLE;
    endcase

    sel_d  = sel_of(state_d);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      par_en_q <= 1'b0;
      sel_q    <= 2'b01;
      ser_q    <= 1'b0;
      par_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      par_en_q <= par_en_d;
      sel_q    <= sel_d;
      ser_q    <= ser_d;
      par_q    <= par_d;
      busy_q   <= busy_d;
    end
  end

  assign SEL      = sel_q;
  assign Ser_Data = ser_q;
  assign Par_Bit  = par_q;
  assign Busy     = busy_q;

endmodule
